// File: rtl/div16_8_seq.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Handshake: start is taken only on an edge where ready=1; done pulses for one cycle as the results update.
`timescale 1ns/1ps
module div16_8_seq #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          ovf,
  output logic          dbz
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [VW-1:0] r;
  logic [DW-1:0] q;
  logic [VW-1:0] dvs;
  logic [VW:0]   t;
  logic [VW:0]   t_sub;
  logic          ge;
  logic [VW-1:0] r_n;
  logic [DW-1:0] q_n;

  // r < dvs always holds, so the borrow out of t - dvs is exactly (t < dvs).
  assign t     = {r, q[DW-1]};
  assign t_sub = t - {1'b0, dvs};
  assign ge    = ~t_sub[VW];
  assign r_n   = ge ? t_sub[VW-1:0] : t[VW-1:0];
  assign q_n   = {q[DW-2:0], ge};

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvs <= divisor;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= '0;
              ovf       <= 1'b1;
              dbz       <= 1'b1;
            end else begin
              cnt <= CW'(DW - 1);
              r   <= '0;
              q   <= dividend;
            end
          end
        end
        RUN: begin
          r <= r_n;
          q <= q_n;
          if (cnt == '0) begin
            quotient  <= q_n;
            remainder <= r_n;
            ovf       <= |q_n[DW-1:VW];
            dbz       <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div16_8_seq.sv
// Directed bench for div16_8_seq: driver tasks push expected results into a queue,
// a monitor pops and compares whenever done is seen.
`timescale 1ns/1ps
module tb_div16_8_seq;
  localparam int W = 26;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dbz;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  int           cyc;
  int           checks;
  int           errors;

  div16_8_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dbz(dbz)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] res(input logic [15:0] q, input logic [7:0] r,
                                       input logic o, input logic z);
    return {q, r, o, z};
  endfunction

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", {31'b0, ready}, 32'd1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [W-1:0] e);
    wait_ready();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(e);
    exp_t_q.push_back(cyc + ((b == 8'd0) ? 1 : 17));
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    int           tt;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done q=%h r=%h (cycle %0d)", quotient, remainder, cyc);
      end else begin
        e  = exp_q.pop_front();
        tt = exp_t_q.pop_front();
        check("result{q,r,ovf,dbz}", {6'b0, quotient, remainder, ovf, dbz}, {6'b0, e});
        check("done_cycle", cyc, tt);
      end
    end
  end

  initial begin
    int c;
    int n;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] p;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #3;
    check("reset_ready", {31'b0, ready}, 32'd1);
    check("reset_outputs", {6'b0, quotient, remainder, ovf, dbz, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic and boundary quotients
    do_op(16'h3039, 8'h7B, res(16'h0064, 8'h2D, 1'b0, 1'b0));
    do_op(16'hFFFF, 8'hFF, res(16'h0101, 8'h00, 1'b1, 1'b0));
    do_op(16'hFFFF, 8'h01, res(16'hFFFF, 8'h00, 1'b1, 1'b0));
    do_op(16'h00FF, 8'h10, res(16'h000F, 8'h0F, 1'b0, 1'b0));
    do_op(16'h00FE, 8'hFF, res(16'h0000, 8'hFE, 1'b0, 1'b0));
    do_op(16'h1000, 8'hFF, res(16'h0010, 8'h10, 1'b0, 1'b0));

    // divide by zero: done in cycle 1, ready again in cycle 2
    wait_ready();
    c = cyc;
    do_op(16'h1234, 8'h00, res(16'hFFFF, 8'h00, 1'b1, 1'b1));
    check("dbz_ready_c1", {31'b0, ready}, 32'd0);
    @(negedge clk);
    check("dbz_ready_c2", {31'b0, ready}, 32'd1);
    check("dbz_cycle_count", cyc - c, 32'd2);

    // inverse of the multiplier
    do_op(16'hFE01, 8'hFF, res(16'h00FF, 8'h00, 1'b0, 1'b0));
    do_op(16'h0000, 8'h05, res(16'h0000, 8'h00, 1'b0, 1'b0));
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(1, 255));
      p  = 16'(a8) * 16'(b8);
      do_op(p, b8, res({8'h00, a8}, 8'h00, 1'b0, 1'b0));
    end

    // start while busy is ignored
    wait_ready();
    do_op(16'h0100, 8'h10, res(16'h0010, 8'h00, 1'b0, 1'b0));
    repeat (4) @(negedge clk);
    start = 1'b1;
    dividend = 16'h0009;
    divisor = 8'h03;
    @(negedge clk);
    start = 1'b0;
    check("busy_ready", {31'b0, ready}, 32'd0);
    wait_ready();
    check("held_quotient", {16'b0, quotient}, 32'h0010);

    // reset mid-operation discards the op
    start = 1'b1;
    dividend = 16'h0100;
    divisor = 8'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ready", {31'b0, ready}, 32'd1);
    check("midreset_outputs", {6'b0, quotient, remainder, ovf, dbz, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0064, 8'h07, res(16'h000E, 8'h02, 1'b0, 1'b0));

    // held start: accepts in cycles 0, 18, 36
    wait_ready();
    start = 1'b1;
    dividend = 16'h3039;
    divisor = 8'h7B;
    exp_q.push_back(res(16'h0064, 8'h2D, 1'b0, 1'b0));
    exp_t_q.push_back(cyc + 17);
    @(negedge clk);
    dividend = 16'h00FF;
    divisor = 8'h10;
    exp_q.push_back(res(16'h000F, 8'h0F, 1'b0, 1'b0));
    exp_t_q.push_back(cyc - 1 + 35);
    repeat (17) @(negedge clk);
    check("b2b_ready_c18", {31'b0, ready}, 32'd1);
    @(negedge clk);
    dividend = 16'hFFFF;
    divisor = 8'hFF;
    exp_q.push_back(res(16'h0101, 8'h00, 1'b1, 1'b0));
    exp_t_q.push_back(cyc - 19 + 53);
    check("b2b_stable_q", {16'b0, quotient}, 32'h0064);
    repeat (17) @(negedge clk);
    check("b2b_ready_c36", {31'b0, ready}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_ready();

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
